fifo_burst_arbiter: RTL and testbench
=====================================

FIFO_BURST_ARBITER -- requirements
Module: fifo_burst_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: width of each data word.
REQ-002 The block SHALL have parameter MAX_BURST, default 8: maximum beats per grant, legal range 1..15.
REQ-003 The block SHALL have parameter CNT_WIDTH, default 4: beat-counter width, large enough to hold MAX_BURST.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 i_enable  input  1  allows new grants; has no effect on a burst in progress.
REQ-008 i_flush  input  1  synchronous abort of the current burst.
REQ-009 i_chN_data  input  DATA_WIDTH  head word of source FIFO N (N=0,1), first-word-fall-through.
REQ-010 i_chN_empty  input  1  source FIFO N empty.
REQ-011 i_chN_almost_empty  input  1  source FIFO N holds at most one word.
REQ-012 o_chN_read_enable  output  1  dequeue strobe to source FIFO N.
REQ-013 o_data  output  DATA_WIDTH  granted channel's head word; 0 when o_valid=0.
REQ-014 o_valid  output  1  o_data carries a valid beat.
REQ-015 i_ready  input  1  downstream accepts the beat; a transfer is o_valid & i_ready.
REQ-016 o_channel  output  1  index of the granted channel; 0 when idle.
REQ-017 o_last  output  1  current beat is the final beat of the burst.
REQ-018 o_busy  output  1  a grant is active.
REQ-019 o_burst_count  output  16  number of completed bursts; wraps from 0xFFFF to 0.

Function
REQ-020 The FSM SHALL have states IDLE, GRANT0 and GRANT1; o_busy=1 exactly in GRANT0 and GRANT1.
REQ-021 In IDLE with i_enable=1 and exactly one channel non-empty, the FSM SHALL move to that channel's GRANT state on the next edge.
REQ-022 In IDLE with i_enable=1 and both channels non-empty, the FSM SHALL grant the channel not equal to r_last_grant; r_last_grant resets to 1, so ch0 wins the first tie.
REQ-023 On entering GRANTn, the block SHALL set r_last_grant=n and r_beat_count=0.
REQ-024 In IDLE, o_valid, both read enables and o_last SHALL be 0; there is no transfer during the grant-decision cycle.
REQ-025 In GRANTn, o_valid SHALL equal !i_chn_empty and o_data SHALL equal i_chn_data.
REQ-026 In GRANTn, o_chn_read_enable SHALL equal o_valid & i_ready, combinationally in the same cycle; the other channel's read enable SHALL be 0.
REQ-027 o_last SHALL equal o_valid & (r_beat_count==MAX_BURST-1 | i_chn_almost_empty).
REQ-028 Each transfer SHALL increment r_beat_count.
REQ-029 A transfer with o_last=1 SHALL end the burst: next state IDLE, and o_burst_count increments.
REQ-030 If i_chn_empty=1 while in GRANTn, the block SHALL make no transfer, go to IDLE, and leave o_burst_count unchanged.
REQ-031 After every burst there SHALL be at least one IDLE cycle, so the minimum grant-to-grant gap is 1 cycle.
REQ-032 With i_ready=0, the block SHALL hold state, counter and grant, and o_data SHALL remain stable while i_chn_empty=0.
REQ-033 When MAX_BURST=1, every beat SHALL have o_last=1.
REQ-034 i_enable=0 SHALL block only the IDLE-to-GRANT transition.
REQ-035 i_flush=1 SHALL take priority over all other inputs in that cycle: the FSM goes to IDLE, r_beat_count=0 and r_last_grant=1.
REQ-036 While i_flush=1, o_valid and both read enables SHALL be forced to 0.
REQ-037 i_flush SHALL leave o_burst_count unchanged.

Reset
REQ-038 On reset=1 at a clock edge, the block SHALL set state=IDLE, r_beat_count=0, r_last_grant=1 and o_burst_count=0.
REQ-039 While reset=1, all outputs SHALL be 0, including read enables, o_valid, o_data, o_channel, o_last and o_busy.
REQ-040 Reset asserted mid-burst SHALL abort the burst with no further read enables.

Verification
REQ-041 Scenario: ch0 holds 3 words, ch1 empty, i_ready=1 -> 1 IDLE cycle, then 3 consecutive beats on ch0, o_last on beat 3, back to IDLE, o_burst_count=1.
REQ-042 Scenario: both channels hold 20 words, MAX_BURST=8 -> grants run ch0(8), ch1(8), ch0(8), with 1 IDLE cycle between bursts and o_last on each 8th beat.
REQ-043 Scenario: i_ready toggled 1,0,1,0 during a ch1 burst -> read enable only in ready cycles, no lost or duplicated words, data order preserved.
REQ-044 Scenario: i_flush pulsed for 1 cycle on beat 4 of a ch0 burst -> no read enable that cycle, IDLE next, o_burst_count unchanged, next tie granted to ch0.
REQ-045 Scenario: i_enable=0 with both channels non-empty -> o_busy stays 0; i_enable deasserted mid-burst -> the current burst completes and no new grant follows.
REQ-046 Scenario: reset asserted during beat 2 -> outputs 0 in the next cycle, o_burst_count=0, first grant after reset release goes to ch0 on a tie.

Source files
------------

// File: rtl/fifo_burst_arbiter.sv
// Two-channel burst arbiter draining first-word-fall-through FIFOs into one stream.
// Round-robin on ties, bursts capped at MAX_BURST beats, with flush and burst counting.
module fifo_burst_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 8,
    parameter int unsigned CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_enable,
    input  logic                  i_flush,
    input  logic [DATA_WIDTH-1:0] i_ch0_data,
    input  logic                  i_ch0_empty,
    input  logic                  i_ch0_almost_empty,
    input  logic [DATA_WIDTH-1:0] i_ch1_data,
    input  logic                  i_ch1_empty,
    input  logic                  i_ch1_almost_empty,
    output logic                  o_ch0_read_enable,
    output logic                  o_ch1_read_enable,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_channel,
    output logic                  o_last,
    output logic                  o_busy,
    output logic [15:0]           o_burst_count
);

    localparam int unsigned BURST_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t                     state, state_next;
    logic [CNT_WIDTH-1:0]       beat_count, beat_count_next;
    logic                       last_grant, last_grant_next;
    logic [BURST_CNT_WIDTH-1:0] burst_count, burst_count_next;

    logic                  sel_ch;
    logic                  sel_empty;
    logic                  sel_almost_empty;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  valid;
    logic                  last;
    logic                  read0;
    logic                  read1;
    logic                  transfer;
    logic                  go0;
    logic                  go1;

    // State, beat counter, round-robin pointer and burst counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            beat_count  <= '0;
            last_grant  <= 1'b1;
            burst_count <= '0;
        end else begin
            state       <= state_next;
            beat_count  <= beat_count_next;
            last_grant  <= last_grant_next;
            burst_count <= burst_count_next;
        end
    end

    // Beat datapath and next-state decision
    always_comb begin
        state_next       = state;
        beat_count_next  = beat_count;
        last_grant_next  = last_grant;
        burst_count_next = burst_count;
        valid            = 1'b0;
        last             = 1'b0;
        read0            = 1'b0;
        read1            = 1'b0;

        sel_ch           = (state == GRANT1);
        sel_empty        = sel_ch ? i_ch1_empty        : i_ch0_empty;
        sel_almost_empty = sel_ch ? i_ch1_almost_empty : i_ch0_almost_empty;
        sel_data         = sel_ch ? i_ch1_data         : i_ch0_data;

        if ((state != IDLE) && !i_flush && !sel_empty) begin
            valid = 1'b1;
            last  = (beat_count == CNT_WIDTH'(MAX_BURST - 1)) || sel_almost_empty;
            read0 = !sel_ch && i_ready;
            read1 = sel_ch && i_ready;
        end
        transfer = valid && i_ready;

        // On a tie the channel that did not win last time is granted
        go0 = !i_ch0_empty && (i_ch1_empty || last_grant);
        go1 = !i_ch1_empty && (i_ch0_empty || !last_grant);

        if (i_flush) begin
            state_next      = IDLE;
            beat_count_next = '0;
            last_grant_next = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_enable && go0) begin
                        state_next      = GRANT0;
                        last_grant_next = 1'b0;
                        beat_count_next = '0;
                    end else if (i_enable && go1) begin
                        state_next      = GRANT1;
                        last_grant_next = 1'b1;
                        beat_count_next = '0;
                    end
                end
                GRANT0, GRANT1: begin
                    if (sel_empty) begin
                        state_next = IDLE;
                    end else if (transfer) begin
                        beat_count_next = beat_count + CNT_WIDTH'(1);
                        if (last) begin
                            state_next       = IDLE;
                            burst_count_next = burst_count + BURST_CNT_WIDTH'(1);
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Outputs are held at zero while reset is asserted
    always_comb begin
        o_valid           = !reset && valid;
        o_last            = !reset && last;
        o_ch0_read_enable = !reset && read0;
        o_ch1_read_enable = !reset && read1;
        o_data            = (!reset && valid) ? sel_data : '0;
        o_busy            = !reset && (state != IDLE);
        o_channel         = !reset && (state == GRANT1);
        o_burst_count     = reset ? '0 : burst_count;
    end

endmodule

// File: tb/tb_fifo_burst_arbiter.sv
// Bench for fifo_burst_arbiter: queue-backed FIFOs, a per-cycle reference model
// of the grant rules, and directed scenarios with hand-computed expectations.
module tb_fifo_burst_arbiter;

    localparam int MB = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_enable;
    logic        i_flush;
    logic [31:0] i_ch0_data;
    logic        i_ch0_empty;
    logic        i_ch0_almost_empty;
    logic [31:0] i_ch1_data;
    logic        i_ch1_empty;
    logic        i_ch1_almost_empty;
    logic        o_ch0_read_enable;
    logic        o_ch1_read_enable;
    logic [31:0] o_data;
    logic        o_valid;
    logic        i_ready;
    logic        o_channel;
    logic        o_last;
    logic        o_busy;
    logic [15:0] o_burst_count;

    fifo_burst_arbiter #(
        .DATA_WIDTH(32),
        .MAX_BURST (MB),
        .CNT_WIDTH (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .i_enable          (i_enable),
        .i_flush           (i_flush),
        .i_ch0_data        (i_ch0_data),
        .i_ch0_empty       (i_ch0_empty),
        .i_ch0_almost_empty(i_ch0_almost_empty),
        .i_ch1_data        (i_ch1_data),
        .i_ch1_empty       (i_ch1_empty),
        .i_ch1_almost_empty(i_ch1_almost_empty),
        .o_ch0_read_enable (o_ch0_read_enable),
        .o_ch1_read_enable (o_ch1_read_enable),
        .o_data            (o_data),
        .o_valid           (o_valid),
        .i_ready           (i_ready),
        .o_channel         (o_channel),
        .o_last            (o_last),
        .o_busy            (o_busy),
        .o_burst_count     (o_burst_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          ch;
        logic [31:0] d;
        logic        last;
    } xfer_t;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    xfer_t       xlog[$];

    bit rst_v = 1'b1;
    bit en_v  = 1'b0;
    bit fl_v  = 1'b0;
    bit rdy_v = 1'b1;

    // Reference model: which channel holds the grant (-1 none), beats done, last winner
    int m_gnt    = -1;
    int m_beats  = 0;
    int m_prev   = 1;
    int m_bursts = 0;

    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        logic [31:0] e_data;
        bit e_valid, e_last, e_busy, e_chan, e_re0, e_re1;
        int sz;
        logic [15:0] e_cnt;
        @(negedge clk);
        cyc++;
        reset              = rst_v;
        i_enable           = en_v;
        i_flush            = fl_v;
        i_ready            = rdy_v;
        i_ch0_data         = (q0.size() > 0) ? q0[0] : 32'h0;
        i_ch1_data         = (q1.size() > 0) ? q1[0] : 32'h0;
        i_ch0_empty        = (q0.size() == 0);
        i_ch1_empty        = (q1.size() == 0);
        i_ch0_almost_empty = (q0.size() <= 1);
        i_ch1_almost_empty = (q1.size() <= 1);
        #1;
        e_data = 32'h0; e_valid = 0; e_last = 0; e_busy = 0; e_chan = 0; e_re0 = 0; e_re1 = 0;
        if (!rst_v && m_gnt >= 0) begin
            e_busy = 1;
            e_chan = (m_gnt == 1);
            sz = (m_gnt == 1) ? q1.size() : q0.size();
            if (!fl_v && sz > 0) begin
                e_valid = 1;
                e_data  = (m_gnt == 1) ? q1[0] : q0[0];
                e_last  = (m_beats + 1 == MB) || (sz <= 1);
                e_re0   = (m_gnt == 0) && rdy_v;
                e_re1   = (m_gnt == 1) && rdy_v;
            end
        end
        e_cnt = rst_v ? 16'h0 : 16'(m_bursts);

        n_chk++;
        if ({o_valid, o_last, o_busy, o_channel, o_ch0_read_enable, o_ch1_read_enable} ===
                {e_valid, e_last, e_busy, e_chan, e_re0, e_re1} &&
            o_data === e_data && o_burst_count === e_cnt)
            n_pass++;
        else
            $display("FAIL cycle %0d: got v%b l%b b%b c%b re%b%b d=%h n=%0d expected v%b l%b b%b c%b re%b%b d=%h n=%0d",
                     cyc, o_valid, o_last, o_busy, o_channel, o_ch0_read_enable, o_ch1_read_enable,
                     o_data, o_burst_count, e_valid, e_last, e_busy, e_chan, e_re0, e_re1, e_data, e_cnt);

        if (rst_v) begin
            m_gnt = -1; m_beats = 0; m_prev = 1; m_bursts = 0;
        end else if (fl_v) begin
            m_gnt = -1; m_beats = 0; m_prev = 1;
        end else if (m_gnt < 0) begin
            if (en_v && (q0.size() > 0 || q1.size() > 0)) begin
                if (q0.size() > 0 && q1.size() > 0) m_gnt = 1 - m_prev;
                else m_gnt = (q0.size() > 0) ? 0 : 1;
                m_prev  = m_gnt;
                m_beats = 0;
            end
        end else if (!e_valid) begin
            m_gnt = -1;
        end else if (rdy_v) begin
            xlog.push_back('{cyc: cyc, ch: m_gnt, d: e_data, last: e_last});
            if (m_gnt == 1) void'(q1.pop_front());
            else void'(q0.pop_front());
            m_beats++;
            if (e_last) begin
                m_gnt = -1;
                m_bursts = (m_bursts + 1) % 65536;
            end
        end
    endtask

    task automatic do_reset();
        q0.delete(); q1.delete();
        rst_v = 1; en_v = 0; fl_v = 0; rdy_v = 1;
        step(); step();
        rst_v = 0;
        xlog.delete();
        cyc = 0;
    endtask

    task automatic load(input int n0, input int n1);
        for (int i = 0; i < n0; i++) q0.push_back(32'hA000_0000 + 32'(i));
        for (int i = 0; i < n1; i++) q1.push_back(32'hB000_0000 + 32'(i));
    endtask

    initial begin
        reset = 1; i_enable = 0; i_flush = 0; i_ready = 1;
        i_ch0_data = 0; i_ch1_data = 0;
        i_ch0_empty = 1; i_ch1_empty = 1; i_ch0_almost_empty = 1; i_ch1_almost_empty = 1;

        // Single short burst on ch0
        do_reset();
        chk("reset_busy", 32'(o_busy), 32'h0);
        chk("reset_count", 32'(o_burst_count), 32'h0);
        load(3, 0); en_v = 1;
        step();
        chk("s1_decide_idle", 32'(o_busy), 32'h0);
        for (int i = 0; i < 4; i++) step();
        chk("s1_nbeats", 32'(xlog.size()), 32'd3);
        chk("s1_first_cyc", 32'(xlog[0].cyc), 32'd2);
        chk("s1_last_cyc", 32'(xlog[2].cyc), 32'd4);
        chk("s1_last_flags", {29'h0, xlog[0].last, xlog[1].last, xlog[2].last}, 32'h1);
        chk("s1_word3", xlog[2].d, 32'hA000_0002);
        chk("s1_count", 32'(o_burst_count), 32'd1);

        // Two full channels alternate max-length bursts
        do_reset();
        load(20, 20); en_v = 1;
        for (int i = 0; i < 27; i++) step();
        en_v = 0; step();
        chk("s2_nbeats", 32'(xlog.size()), 32'd24);
        chk("s2_b1_last", 32'(xlog[7].last), 32'h1);
        chk("s2_b1_notlast", 32'(xlog[6].last), 32'h0);
        chk("s2_b2_ch", 32'(xlog[8].ch), 32'd1);
        chk("s2_b2_cyc", 32'(xlog[8].cyc), 32'd11);
        chk("s2_b3_ch", 32'(xlog[16].ch), 32'd0);
        chk("s2_b3_data", xlog[16].d, 32'hA000_0008);
        chk("s2_b3_last", 32'(xlog[23].last), 32'h1);
        chk("s2_count", 32'(o_burst_count), 32'd3);

        // Backpressure during a ch1 burst
        do_reset();
        load(0, 3); en_v = 1;
        step();
        rdy_v = 1; step();
        rdy_v = 0; step();
        chk("s3_stall_re", 32'(o_ch1_read_enable), 32'h0);
        chk("s3_stall_data", o_data, 32'hB000_0001);
        rdy_v = 1; step();
        rdy_v = 0; step();
        rdy_v = 1; step();
        step();
        chk("s3_nbeats", 32'(xlog.size()), 32'd3);
        chk("s3_cycles", {8'h0, 8'(xlog[0].cyc), 8'(xlog[1].cyc), 8'(xlog[2].cyc)}, 32'h0002_0406);
        chk("s3_order", xlog[1].d, 32'hB000_0001);
        chk("s3_last", 32'(xlog[2].last), 32'h1);

        // Flush on the fourth beat of a ch0 burst
        do_reset();
        load(10, 10); en_v = 1;
        for (int i = 0; i < 4; i++) step();
        fl_v = 1; step();
        chk("s4_flush_re", 32'(o_ch0_read_enable), 32'h0);
        chk("s4_flush_valid", 32'(o_valid), 32'h0);
        fl_v = 0; step();
        chk("s4_idle_after", 32'(o_busy), 32'h0);
        chk("s4_count", 32'(o_burst_count), 32'h0);
        step();
        chk("s4_regrant_ch", 32'(o_channel), 32'h0);
        chk("s4_regrant_data", o_data, 32'hA000_0003);
        chk("s4_nbeats", 32'(xlog.size()), 32'd4);

        // Enable gating
        do_reset();
        load(3, 5); en_v = 0;
        for (int i = 0; i < 4; i++) step();
        chk("s5_disabled_busy", 32'(o_busy), 32'h0);
        en_v = 1; step();
        en_v = 0;
        for (int i = 0; i < 7; i++) step();
        chk("s5_nbeats", 32'(xlog.size()), 32'd3);
        chk("s5_count", 32'(o_burst_count), 32'd1);
        chk("s5_no_regrant", 32'(o_busy), 32'h0);

        // Reset mid-burst
        do_reset();
        load(5, 5); en_v = 1;
        step(); step();
        rst_v = 1; step();
        chk("s6_rst_valid", 32'(o_valid), 32'h0);
        chk("s6_rst_re", 32'(o_ch0_read_enable), 32'h0);
        rst_v = 0; step();
        chk("s6_post_busy", 32'(o_busy), 32'h0);
        chk("s6_post_count", 32'(o_burst_count), 32'h0);
        step();
        chk("s6_tie_ch", 32'(o_channel), 32'h0);
        chk("s6_data", o_data, 32'hA000_0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
